// File: rtl/demux32_pipe.sv
// rtl/demux32_pipe.sv - registered 1-to-2 valid/ready demux with one-entry holding register per output
// Optional beat counters enabled by defining DEMUX32_STATS_EN.
`ifndef WIDTH
`define WIDTH 32
`endif

module demux32_pipe #(
    parameter int WIDTH = `WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
);

    logic a_free;
    logic b_free;
    logic acc_a;
    logic acc_b;

    // A slot can take a beat when empty or when its current beat leaves this cycle.
    assign a_free   = !a_valid || a_ready;
    assign b_free   = !b_valid || b_ready;
    assign in_ready = in_sel ? b_free : a_free;
    assign acc_a    = in_valid && !in_sel && a_free;
    assign acc_b    = in_valid &&  in_sel && b_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_data  <= '0;
        end else if (acc_a) begin
            a_valid <= 1'b1;
            a_data  <= in_data;
        end else if (a_ready) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
        end else if (acc_b) begin
            b_valid <= 1'b1;
            b_data  <= in_data;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

`ifdef DEMUX32_STATS_EN
    // Counters saturate rather than wrap so a long run never reads as a short one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= 16'h0000;
            cnt_b <= 16'h0000;
        end else begin
            if (a_valid && a_ready && (cnt_a != 16'hFFFF))
                cnt_a <= cnt_a + 16'h0001;
            if (b_valid && b_ready && (cnt_b != 16'hFFFF))
                cnt_b <= cnt_b + 16'h0001;
        end
    end
`else
    assign cnt_a = 16'h0000;
    assign cnt_b = 16'h0000;
`endif

endmodule

// File: tb/tb_demux32_pipe.sv
// tb/tb_demux32_pipe.sv - directed and random checks of demux32_pipe against a queue-based model
module tb_demux32_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sel;
    logic [31:0] in_data;
    logic        in_ready;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_data;
    logic        b_ready;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int ca = 0;
    int cb = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    demux32_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef DEMUX32_STATS_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Called just after a falling edge; leaves the bench just after the next falling edge.
    task automatic step(input logic v, input logic s, input logic [31:0] d,
                        input logic ar, input logic br);
        logic exp_rdy;
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        #1;
        exp_rdy = s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
        check("in_ready", in_ready, exp_rdy);
        check("a_valid", a_valid, qa.size() != 0);
        check("b_valid", b_valid, qb.size() != 0);
        if (qa.size() != 0) check("a_data", a_data, qa[0]);
        if (qb.size() != 0) check("b_data", b_data, qb[0]);
        check("cnt_a", cnt_a, exp_cnt(ca));
        check("cnt_b", cnt_b, exp_cnt(cb));
        @(posedge clk);
        if (ar && qa.size() != 0) begin void'(qa.pop_front()); if (ca < 65535) ca++; end
        if (br && qb.size() != 0) begin void'(qb.pop_front()); if (cb < 65535) cb++; end
        if (v && exp_rdy) begin
            accepts++;
            if (s) qb.push_back(d); else qa.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_valid"}, a_valid, 1'b0);
        check({tag, "_b_valid"}, b_valid, 1'b0);
        check({tag, "_a_data"}, a_data, 32'h0);
        check({tag, "_b_data"}, b_data, 32'h0);
        check({tag, "_cnt_a"}, cnt_a, 16'h0);
        check({tag, "_cnt_b"}, cnt_b, 16'h0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int acc0;
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'h0; a_ready = 1'b0; b_ready = 1'b0;
        #1;
        check_reset_state("por");
        in_sel = 1'b1; #1;
        check("por_in_ready_sel1", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic routing: A then B, one-cycle pulses.
        step(1, 0, 32'hDEADBEEF, 1, 1);
        step(1, 1, 32'h12345678, 1, 1);
        check("route_a_data", a_data, 32'hDEADBEEF);
        step(0, 0, 32'h0, 1, 1);
        check("route_b_data", b_data, 32'h12345678);
        step(0, 0, 32'h0, 1, 1);

        // Backpressure on A, B still open.
        step(1, 0, 32'h1, 0, 0);
        step(1, 0, 32'h2, 0, 0);
        check("bp_hold_a_data", a_data, 32'h1);
        step(0, 1, 32'h0, 0, 0);
        step(1, 0, 32'h2, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 1);

        // Pass-through refill.
        step(1, 0, 32'hA, 0, 1);
        step(1, 0, 32'hB, 1, 1);
        check("refill_a_valid", a_valid, 1'b1);
        check("refill_a_data", a_data, 32'hB);
        step(0, 0, 32'h0, 1, 1);

        // Alternating stream, full throughput.
        acc0 = accepts;
        for (int i = 0; i < 8; i++) step(1, i[0], i, 1, 1);
        check("stream_accepts", accepts - acc0, 8);
        step(0, 0, 32'h0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        // Asynchronous reset with both outputs full and stalled.
        step(0, 0, 32'h0, 1, 1);
        step(1, 0, 32'h55, 0, 0);
        step(1, 1, 32'h66, 0, 0);
        check("pre_rst_a_valid", a_valid, 1'b1);
        check("pre_rst_b_valid", b_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        qa.delete(); qb.delete(); ca = 0; cb = 0;
        step(1, 1, 32'hCAFEF00D, 1, 1);
        check("post_rst_b_data", b_data, 32'hCAFEF00D);
        step(0, 0, 32'h0, 1, 1);

        // Statistics: 3 to A, 5 to B from a fresh reset.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        qa.delete(); qb.delete(); ca = 0; cb = 0;
        for (int i = 0; i < 8; i++) step(1, i >= 3, 32'h100 + i, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        #1;
`ifdef DEMUX32_STATS_EN
        check("stats_cnt_a_3", cnt_a, 16'd3);
        check("stats_cnt_b_5", cnt_b, 16'd5);
        for (int i = 0; i < 65540; i++) step(1, 0, i, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        #1;
        check("stats_cnt_a_sat", cnt_a, 16'hFFFF);
`else
        check("stats_cnt_a_off", cnt_a, 16'd0);
        check("stats_cnt_b_off", cnt_b, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
